wdt_recovery_sequencer: RTL
===========================

// Module: wdt_recovery_sequencer
// PURPOSE
//  Controller for watchdog_timer; drives its enable and heartbeat inputs and consumes its force_reset output.
//  Merges liveness pulses from N_SRC subsystems into one watchdog heartbeat.
//  On a watchdog bite: holds the system in reset, re-arms after a boot grace window, and locks out after repeated failures.
// PARAMETERS
//  N_SRC             4     number of liveness sources
//  RESET_HOLD_CYCLES 16    cycles sys_reset_n held low per bite (>=1)
//  BOOT_GRACE_CYCLES 1024  cycles with watchdog disabled after arm/recovery (>=1)
//  MAX_RETRIES       3     consecutive bites before LOCKOUT (1..15)
// PORTS
//  clk             in   1      system clock
//  rstn            in   1      async active-low reset
//  arm             in   1      level; software request to supervise
//  src_alive       in   N_SRC  per-source 1-cycle liveness pulses
//  src_mask        in   N_SRC  1 = source ignored
//  wdt_force_reset in   1      bite from watchdog_timer
//  clear_lockout   in   1      1-cycle pulse; exits LOCKOUT
//  wdt_enable      out  1      to watchdog_timer.enable
//  wdt_heartbeat   out  1      to watchdog_timer.heartbeat; 1-cycle pulse
//  sys_reset_n     out  1      active-low system reset request
//  lockout         out  1      high while in LOCKOUT
//  retry_count     out  4      consecutive bites since last healthy heartbeat
//  fault_total     out  8      saturating bite count; cleared only by rstn
//  state           out  3      IDLE=0 GRACE=1 RUN=2 HOLD=3 LOCKOUT=4
// BEHAVIOUR
//  All outputs are registered.
//  Reset values: state=IDLE, wdt_enable=0, wdt_heartbeat=0, sys_reset_n=1, lockout=0, counts=0, alive bitmap=0.
//  Transitions take effect on the edge that samples the condition; outputs reflect the new state in the following cycle.
//  IDLE: wdt_enable=0, sys_reset_n=1. arm=1 -> GRACE.
//  GRACE: wdt_enable=0, sys_reset_n=1. Lasts exactly BOOT_GRACE_CYCLES cycles, then -> RUN.
//   arm=0 -> IDLE, taking priority over timeout.
//  RUN: wdt_enable=1.
//   wdt_force_reset=1 -> HOLD; retry_count+1 (saturates at 15); fault_total+1 (saturates at 255).
//   Otherwise arm=0 -> IDLE. Bite beats arm=0 when both occur in the same cycle.
//  HOLD: sys_reset_n=0, wdt_enable=0 for exactly RESET_HOLD_CYCLES cycles.
//   Then retry_count>=MAX_RETRIES -> LOCKOUT; else arm=1 -> GRACE; else -> IDLE.
//  LOCKOUT: sys_reset_n=0, wdt_enable=0, lockout=1. Only exit: clear_lockout -> IDLE with retry_count=0.
//   arm is ignored.
//  wdt_force_reset is ignored outside RUN. clear_lockout is ignored outside LOCKOUT.
//  Heartbeat (RUN only):
//   - Bitmap seen |= src_alive & ~src_mask each cycle.
//   - When (seen | src_alive) covers every unmasked bit, wdt_heartbeat=1 next cycle. On that edge seen clears to 0.
//   - Pulses in the completing cycle count only toward the current heartbeat.
//   - All sources masked -> no heartbeat is ever issued; the watchdog bites by design.
//   - Mask changes apply immediately; bits set while masked do not count.
//  The first heartbeat after entering RUN clears retry_count (healthy boot).
//   On the same cycle a bite wins: no heartbeat issues and retry_count increments.
//  seen clears on any exit from RUN. wdt_heartbeat is never high outside RUN.
//  Counters are sized $clog2 of the max of the two cycle parameters; no wrap within a phase.
//  Async rstn mid-HOLD/LOCKOUT releases sys_reset_n immediately (1) and returns to IDLE.
// TESTING (N_SRC=2, HOLD=4, GRACE=8, MAX_RETRIES=2)
//  1 arm=1 at cycle 0 -> state GRACE at cycle 1, RUN at cycle 9, wdt_enable=1 from cycle 9.
//  2 RUN, mask=00: alive=01 then alive=10 two cycles later -> one heartbeat pulse the cycle after the 10 pulse.
//    Repeating alive=01 alone -> no pulse.
//  3 RUN, mask=10, alive=01 -> heartbeat next cycle; mask=11 -> no heartbeat for 100 cycles.
//  4 Bite in RUN -> sys_reset_n=0 exactly 4 cycles, retry_count=1, fault_total=1, then GRACE.
//    A second bite without a heartbeat -> LOCKOUT, lockout=1, sys_reset_n stays 0.
//  5 LOCKOUT with arm=1 for 50 cycles -> remains LOCKOUT; clear_lockout -> IDLE, retry_count=0, sys_reset_n=1.
//  6 Bite and arm=0 in the same cycle -> HOLD; rstn low mid-HOLD -> sys_reset_n=1, state=IDLE immediately.

Source files
------------

// File: rtl/wdt_recovery_sequencer_if.sv
// Signal bundle between the recovery sequencer and its surroundings:
// software control, subsystem liveness, the watchdog_timer link and status.
interface wdt_recovery_sequencer_if #(
  parameter int N_SRC = 4
);
  logic             arm;
  logic [N_SRC-1:0] src_alive;
  logic [N_SRC-1:0] src_mask;
  logic             wdt_force_reset;
  logic             clear_lockout;
  logic             wdt_enable;
  logic             wdt_heartbeat;
  logic             sys_reset_n;
  logic             lockout;
  logic [3:0]       retry_count;
  logic [7:0]       fault_total;
  logic [2:0]       state;

  // Sequencer side
  modport slave (
    input  arm, src_alive, src_mask, wdt_force_reset, clear_lockout,
    output wdt_enable, wdt_heartbeat, sys_reset_n, lockout,
           retry_count, fault_total, state
  );

  // Controlling side (software, subsystems, watchdog)
  modport master (
    output arm, src_alive, src_mask, wdt_force_reset, clear_lockout,
    input  wdt_enable, wdt_heartbeat, sys_reset_n, lockout,
           retry_count, fault_total, state
  );
endinterface

// File: rtl/wdt_recovery_sequencer.sv
// Watchdog recovery sequencer: merges per-source liveness pulses into one
// heartbeat for watchdog_timer, holds the system in reset after a bite,
// re-arms through a boot grace window and locks out after repeated bites.
module wdt_recovery_sequencer #(
  parameter int N_SRC             = 4,
  parameter int RESET_HOLD_CYCLES = 16,
  parameter int BOOT_GRACE_CYCLES = 1024,
  parameter int MAX_RETRIES       = 3
) (
  input  logic                     clk,
  input  logic                     rstn,
  wdt_recovery_sequencer_if.slave  bus
);

  localparam logic [2:0] S_IDLE    = 3'd0;
  localparam logic [2:0] S_GRACE   = 3'd1;
  localparam logic [2:0] S_RUN     = 3'd2;
  localparam logic [2:0] S_HOLD    = 3'd3;
  localparam logic [2:0] S_LOCKOUT = 3'd4;

  // One phase counter serves both timed phases, so size it for the longer one.
  localparam int CNT_MAX = (RESET_HOLD_CYCLES > BOOT_GRACE_CYCLES) ?
                           RESET_HOLD_CYCLES : BOOT_GRACE_CYCLES;
  localparam int CNT_W   = (CNT_MAX > 1) ? $clog2(CNT_MAX) : 1;

  localparam logic [CNT_W-1:0] GRACE_LAST = CNT_W'(BOOT_GRACE_CYCLES - 1);
  localparam logic [CNT_W-1:0] HOLD_LAST  = CNT_W'(RESET_HOLD_CYCLES - 1);
  localparam logic [3:0]       RETRY_LIM  = 4'(MAX_RETRIES);
  localparam logic [N_SRC-1:0] ALL_SRC    = {N_SRC{1'b1}};

  logic [2:0]       state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [N_SRC-1:0] seen_q, seen_d;
  logic [3:0]       retry_q, retry_d;
  logic [7:0]       fault_q, fault_d;
  logic             hb_d, hb_q;
  logic             enable_q;
  logic             sys_reset_n_q;
  logic             lockout_q;
  logic             covered;
  logic [3:0]       retry_inc;
  logic [7:0]       fault_inc;

  // Every unmasked source has pulsed since the last heartbeat, counting this
  // cycle's pulses. Masked bits are treated as covered; an all-masked vector
  // never completes so the watchdog is left to bite.
  assign covered = ((seen_q | bus.src_alive | bus.src_mask) == ALL_SRC) &&
                   (bus.src_mask != ALL_SRC);

  assign retry_inc = (retry_q == 4'd15)  ? retry_q : retry_q + 4'd1;
  assign fault_inc = (fault_q == 8'd255) ? fault_q : fault_q + 8'd1;

  // Next-state, phase counter, liveness bitmap and fault bookkeeping.
  always_comb begin
    // NOTE: every variable gets a default before the case so no path leaves
    // one unassigned, which would otherwise infer a latch.
    state_d = state_q;
    cnt_d   = cnt_q;
    seen_d  = seen_q;
    retry_d = retry_q;
    fault_d = fault_q;
    hb_d    = 1'b0;

    case (state_q)
      S_IDLE: begin
        if (bus.arm) begin
          state_d = S_GRACE;
          cnt_d   = '0;
        end
      end

      S_GRACE: begin
        if (!bus.arm) begin
          state_d = S_IDLE;
        end else if (cnt_q == GRACE_LAST) begin
          state_d = S_RUN;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end

      S_RUN: begin
        if (bus.wdt_force_reset) begin
          // A bite wins over a heartbeat completing in the same cycle.
          state_d = S_HOLD;
          cnt_d   = '0;
          seen_d  = '0;
          retry_d = retry_inc;
          fault_d = fault_inc;
        end else if (!bus.arm) begin
          state_d = S_IDLE;
          seen_d  = '0;
        end else if (covered) begin
          // Any heartbeat proves a healthy boot, so the retry run ends here.
          hb_d    = 1'b1;
          seen_d  = '0;
          retry_d = '0;
        end else begin
          seen_d = seen_q | (bus.src_alive & ~bus.src_mask);
        end
      end

      S_HOLD: begin
        if (cnt_q == HOLD_LAST) begin
          if (retry_q >= RETRY_LIM) begin
            state_d = S_LOCKOUT;
          end else if (bus.arm) begin
            state_d = S_GRACE;
            cnt_d   = '0;
          end else begin
            state_d = S_IDLE;
          end
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end

      S_LOCKOUT: begin
        if (bus.clear_lockout) begin
          state_d = S_IDLE;
          retry_d = '0;
        end
      end

      default: begin
        state_d = S_IDLE;
        seen_d  = '0;
      end
    endcase
  end

  // State, counters and registered outputs decoded from the next state.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state_q       <= S_IDLE;
      cnt_q         <= '0;
      seen_q        <= '0;
      retry_q       <= '0;
      fault_q       <= '0;
      hb_q          <= 1'b0;
      enable_q      <= 1'b0;
      sys_reset_n_q <= 1'b1;
      lockout_q     <= 1'b0;
    end else begin
      // NOTE: non-blocking assignments so every flop samples pre-edge values.
      state_q       <= state_d;
      cnt_q         <= cnt_d;
      seen_q        <= seen_d;
      retry_q       <= retry_d;
      fault_q       <= fault_d;
      hb_q          <= hb_d;
      enable_q      <= (state_d == S_RUN);
      sys_reset_n_q <= !((state_d == S_HOLD) || (state_d == S_LOCKOUT));
      lockout_q     <= (state_d == S_LOCKOUT);
    end
  end

  assign bus.state         = state_q;
  assign bus.wdt_enable    = enable_q;
  assign bus.wdt_heartbeat = hb_q;
  assign bus.sys_reset_n   = sys_reset_n_q;
  assign bus.lockout       = lockout_q;
  assign bus.retry_count   = retry_q;
  assign bus.fault_total   = fault_q;

endmodule
